// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - round-robin DMA port arbiter with burst limit and stalled-transfer watchdog
module dma_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAXBURST   = 16,
    parameter int TMO_CYCLES = 1023
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NREQ-1:0]      m_req,
    output logic [NREQ-1:0]      m_gnt,
    input  logic [18*NREQ-1:0]   m_adr,
    input  logic [NREQ-1:0]      m_stb,
    input  logic [NREQ-1:0]      m_we,
    input  logic [2*NREQ-1:0]    m_sel,
    input  logic [16*NREQ-1:0]   m_dat,
    output logic [NREQ-1:0]      m_ack,
    output logic [NREQ-1:0]      m_err,
    output logic                 dma_req,
    input  logic                 dma_ack,
    output logic [17:0]          dma_adr18,
    output logic                 dma_stb,
    output logic                 dma_we,
    output logic [1:0]           dma_sel,
    output logic [15:0]          dma_dat_o,
    input  logic                 wb_ack_i,
    output logic                 dma_timeout
);
    localparam int OW = $clog2(NREQ);
    localparam logic [15:0] BURST_SAT = (MAXBURST == 0) ? 16'hFFFF : 16'(MAXBURST);

    typedef enum logic [1:0] {S_IDLE, S_WAITG, S_GRANT, S_REL} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   rr_q, rr_d, owner_q, owner_d, pick, idx, owner_inc;
    logic            pick_vld;
    logic            dma_req_q, dma_req_d;
    logic [NREQ-1:0] gnt_q, gnt_d, owner_oh;
    logic [15:0]     burst_q, burst_d;
    logic [9:0]      wdog_q, wdog_d;
    logic            own_ack, other_req, tmo, release_now;

    // Walk downward so the requester closest above rr_q is the last (winning) write.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = OW'((int'(rr_q) + i) % NREQ);
            if (m_req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    assign owner_inc = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + OW'(1);

    // gnt_q only ever holds the owner's bit, so it doubles as the datapath gate.
    always_comb begin
        dma_adr18 = '0;
        dma_stb   = 1'b0;
        dma_we    = 1'b0;
        dma_sel   = '0;
        dma_dat_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i] && owner_q == OW'(i)) begin
                dma_adr18 = m_adr[18*i +: 18];
                dma_stb   = m_stb[i];
                dma_we    = m_we[i];
                dma_sel   = m_sel[2*i +: 2];
                dma_dat_o = m_dat[16*i +: 16];
            end
        end
    end

    assign own_ack     = wb_ack_i & dma_stb;
    assign other_req   = |(m_req & ~owner_oh);
    assign tmo         = dma_stb & ~wb_ack_i & (wdog_q == 10'(TMO_CYCLES));
    assign m_ack       = own_ack ? owner_oh : '0;
    assign m_err       = tmo ? owner_oh : '0;
    assign dma_timeout = tmo;
    assign m_gnt       = gnt_q;
    assign dma_req     = dma_req_q;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        dma_req_d   = dma_req_q;
        gnt_d       = gnt_q;
        burst_d     = burst_q;
        wdog_d      = '0;
        release_now = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    owner_d   = pick;
                    dma_req_d = 1'b1;
                    state_d   = S_WAITG;
                end
            end
            S_WAITG: begin
                if (!m_req[owner_q]) begin
                    dma_req_d = 1'b0;
                    rr_d      = owner_inc;
                    state_d   = S_REL;
                end else if (dma_ack) begin
                    gnt_d   = owner_oh;
                    burst_d = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (own_ack && burst_q != BURST_SAT) begin
                    burst_d = burst_q + 16'd1;
                end
                if (dma_stb && !wb_ack_i && wdog_q != 10'(TMO_CYCLES)) begin
                    wdog_d = wdog_q + 10'd1;
                end
                release_now = tmo
                    || (!m_req[owner_q] && !m_stb[owner_q])
                    || (MAXBURST != 0 && burst_q >= BURST_SAT && other_req && !m_stb[owner_q]);
                if (release_now) begin
                    gnt_d     = '0;
                    dma_req_d = 1'b0;
                    rr_d      = owner_inc;
                    state_d   = S_REL;
                end
            end
            S_REL: begin
                if (!dma_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            owner_q   <= '0;
            dma_req_q <= 1'b0;
            gnt_q     <= '0;
            burst_q   <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            dma_req_q <= dma_req_d;
            gnt_q     <= gnt_d;
            burst_q   <= burst_d;
            wdog_q    <= wdog_d;
        end
    end
endmodule
